// File: rtl/logic_pkg.sv
// Shared op-code definitions for the logic unit pipeline and the ALU control decoder.
package logic_pkg;

  localparam int OPW_DEFAULT = 3;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_RAND = 3'b101;

endpackage

// File: rtl/pipe_stage.sv
// Valid/data pipeline register with load enable and asynchronous active-low clear.
module pipe_stage #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         next_valid,
  input  logic [W-1:0] next_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RST_DATA;
    end else if (load) begin
      valid <= next_valid;
      data  <= next_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit: S1 holds operands, S2 holds the decoded result.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = OPW_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   Op,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] O,
  output logic             Zero,
  output logic             IllegalOp,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int S1W = 2*WIDTH + OPW;
  localparam int S2W = WIDTH + 2;
  // S2 layout is {illegal, zero, result}; reset shows an all-zero, legal result
  localparam logic [S2W-1:0] S2_RST = {1'b0, 1'b1, {WIDTH{1'b0}}};

  logic             v1, v2;
  logic             adv;
  logic [S1W-1:0]   d1;
  logic [S2W-1:0]   d2;
  logic [WIDTH-1:0] a1, b1;
  logic [OPW-1:0]   op1;
  logic [WIDTH-1:0] res;
  logic             ill;
  logic             res_zero;

  assign adv     = !v2 || OutReady;
  assign InReady = !v1 || adv;

  pipe_stage #(.W(S1W)) u_s1 (
    .clk        (Clk),
    .rst_n      (Rst),
    .load       (InReady),
    .next_valid (InValid),
    .next_data  ({Op, B, A}),
    .valid      (v1),
    .data       (d1)
  );

  assign a1  = d1[WIDTH-1:0];
  assign b1  = d1[2*WIDTH-1:WIDTH];
  assign op1 = d1[S1W-1:2*WIDTH];

  always_comb begin
    res = '0;
    ill = 1'b0;
    case (op1)
      OPW'(OP_AND):  res = a1 & b1;
      OPW'(OP_OR):   res = a1 | b1;
      OPW'(OP_XOR):  res = a1 ^ b1;
      OPW'(OP_NOR):  res = ~(a1 | b1);
      OPW'(OP_ANDN): res = a1 & ~b1;
      OPW'(OP_RAND): res = WIDTH'(&(a1 & b1));
      default:       ill = 1'b1;
    endcase
  end

  assign res_zero = (res == '0);

  pipe_stage #(.W(S2W), .RST_DATA(S2_RST)) u_s2 (
    .clk        (Clk),
    .rst_n      (Rst),
    .load       (adv),
    .next_valid (v1),
    .next_data  ({ill, res_zero, res}),
    .valid      (v2),
    .data       (d2)
  );

  assign O         = d2[WIDTH-1:0];
  assign Zero      = d2[WIDTH];
  assign IllegalOp = d2[WIDTH+1];
  assign OutValid  = v2;

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and result width in bits; legal range is 1..64.
REQ-002 The block SHALL take parameter OPW, default 3, as the width of the operation select.
REQ-003 Port Clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port Rst, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port A, input, WIDTH bits, SHALL be operand A.
REQ-006 Port B, input, WIDTH bits, SHALL be operand B.
REQ-007 Port Op, input, OPW bits, SHALL be the operation select.
REQ-008 Port InValid, input, 1 bit, SHALL indicate that A, B and Op are valid.
REQ-009 Port InReady, output, 1 bit, SHALL indicate that the block accepts input this cycle.
REQ-010 Port O, output, WIDTH bits, SHALL be the result.
REQ-011 Port Zero, output, 1 bit, SHALL be high when O is all zeros.
REQ-012 Port IllegalOp, output, 1 bit, SHALL flag that O came from an unassigned Op code.
REQ-013 Port OutValid, output, 1 bit, SHALL indicate that O, Zero and IllegalOp are valid.
REQ-014 Port OutReady, input, 1 bit, SHALL indicate that the consumer accepts the output.

Function
REQ-015 Op encoding SHALL be fixed as follows: 000 A&B; 001 A|B; 010 A^B; 011 ~(A|B); 100 A&~B; 101 reduce-AND of (A&B) in bit 0, upper bits 0; 110 and 111 illegal.
REQ-016 An illegal Op SHALL give O=0, Zero=1 and IllegalOp=1; every legal Op SHALL give IllegalOp=0.
REQ-017 A transfer SHALL occur on a cycle where InValid&InReady is high (input side) or OutValid&OutReady is high (output side).
REQ-018 The pipeline SHALL have two stages: S1 registers A, B, Op and v1; S2 registers O, Zero, IllegalOp and v2.
REQ-019 The latency SHALL be exactly 2 cycles from input transfer to OutValid when OutReady is held high.
REQ-020 Sustained throughput SHALL be one result per cycle with no bubbles while OutReady is high.
REQ-021 S2 SHALL load when (!v2 | OutReady); S1 SHALL advance into S2 under the same condition.
REQ-022 InReady SHALL equal !v1 | !v2 | OutReady and SHALL be combinational from state and OutReady only; it SHALL NOT depend on InValid.
REQ-023 While OutValid=1 and OutReady=0, O, Zero and IllegalOp SHALL hold stable.
REQ-024 Under a stall, at most 2 items SHALL be held; no item SHALL be dropped or duplicated.
REQ-025 Simultaneous input and output transfers SHALL advance both stages in the same cycle.
REQ-026 Result ordering SHALL equal input ordering.
REQ-027 WIDTH=1 SHALL be legal; the reduce-AND result then equals A&B.

Reset
REQ-028 Assertion of Rst (low) SHALL immediately clear v1 and v2, giving OutValid=0 and IllegalOp=0, with no clock edge required.
REQ-029 Reset SHALL set O=0 and Zero=1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight items.
REQ-031 InReady SHALL be 1 during and after reset.
REQ-032 The first transfer after reset SHALL be accepted on the first rising Clk edge after Rst deasserts.

Structure
REQ-033 The Op code constants and the OPW default SHALL live in shared package logic_pkg, which is also used by the ALU control decoder.
REQ-034 A single sub-module, pipe_stage (parametrised valid/data register with load enable and async active-low clear), SHALL be instantiated once per stage.
REQ-035 The combinational op decode SHALL sit between S1 and S2.

Verification
REQ-036 Reset, then A=0xF0F0F0F0, B=0xFF00FF00, Op=000, with OutReady=1 -> two cycles later OutValid=1, O=0xF000F000, Zero=0.
REQ-037 Back-to-back Op 001, 010, 011, 100 on the REQ-036 operands with OutReady=1 -> outputs on consecutive cycles: 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F, 0x00F000F0.
REQ-038 Op=101 with A=B=0xFFFFFFFF -> O=1; then A=0xFFFFFFFE, B=0xFFFFFFFF -> O=0, Zero=1.
REQ-039 OutReady=0 with three inputs presented -> InReady falls after 2 accepted; O is held stable; on OutReady=1 results emerge in order with no loss.
REQ-040 Op=110 -> O=0, Zero=1, IllegalOp=1.
REQ-041 Rst pulsed low while 2 items are in flight -> OutValid=0 immediately and no stale output appears afterwards.
